// File: rtl/sodor5_wb_scoreboard.sv
// Pair-wise, in-order checker of core vs. model register writebacks, one FIFO per side.
// Optional watchdog enabled by defining SCOREBOARD_TIMEOUT_EN.
module sodor5_wb_scoreboard #(
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned CNT_W            = 16,
    parameter int unsigned DROP_X0          = 1,
    parameter int unsigned STOP_ON_MISMATCH = 1,
    parameter int unsigned TIMEOUT_CYCLES   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dut_wb_valid,
    input  logic [4:0]               dut_wb_rd,
    input  logic [31:0]              dut_wb_data,
    input  logic                     ref_wb_valid,
    input  logic [4:0]               ref_wb_rd,
    input  logic [31:0]              ref_wb_data,
    output logic [CNT_W-1:0]         match_count,
    output logic [CNT_W-1:0]         mismatch_count,
    output logic                     error,
    output logic                     overflow,
    output logic                     timeout,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   pending_dut,
    output logic [$clog2(DEPTH):0]   pending_ref,
    output logic [9:0]               first_mm_rd,
    output logic [63:0]              first_mm_data
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {S_RUN, S_HALT} state_t;
    typedef logic [36:0] entry_t;

    state_t            state_q, state_d;
    entry_t            dut_mem_q [DEPTH];
    entry_t            dut_mem_d [DEPTH];
    entry_t            ref_mem_q [DEPTH];
    entry_t            ref_mem_d [DEPTH];
    logic [PW-1:0]     dut_wr_q, dut_wr_d, dut_rd_q, dut_rd_d;
    logic [PW-1:0]     ref_wr_q, ref_wr_d, ref_rd_q, ref_rd_d;
    logic [CNT_W-1:0]  match_q, match_d, mm_q, mm_d;
    logic              error_q, error_d, overflow_q, overflow_d;
    logic [9:0]        fmm_rd_q, fmm_rd_d;
    logic [63:0]       fmm_data_q, fmm_data_d;

    logic [PW-1:0]     dut_cnt, ref_cnt;
    logic              dut_empty, ref_empty, dut_full, ref_full;
    logic              dut_push, ref_push, dut_acc, ref_acc, pop;
    entry_t            dut_head, ref_head;

    always_comb begin
        dut_cnt   = dut_wr_q - dut_rd_q;
        ref_cnt   = ref_wr_q - ref_rd_q;
        dut_empty = (dut_cnt == '0);
        ref_empty = (ref_cnt == '0);
        dut_full  = (dut_cnt == PW'(DEPTH));
        ref_full  = (ref_cnt == PW'(DEPTH));
        dut_head  = dut_mem_q[dut_rd_q[AW-1:0]];
        ref_head  = ref_mem_q[ref_rd_q[AW-1:0]];
        dut_push  = dut_wb_valid && !((DROP_X0 != 0) && (dut_wb_rd == 5'd0));
        ref_push  = ref_wb_valid && !((DROP_X0 != 0) && (ref_wb_rd == 5'd0));
        pop       = (state_q == S_RUN) && !dut_empty && !ref_empty;
        // A full FIFO still accepts a push when its head leaves on the same edge.
        dut_acc   = dut_push && (!dut_full || pop);
        ref_acc   = ref_push && (!ref_full || pop);
    end

    always_comb begin
        state_d    = state_q;
        dut_mem_d  = dut_mem_q;
        ref_mem_d  = ref_mem_q;
        dut_wr_d   = dut_wr_q;
        dut_rd_d   = dut_rd_q;
        ref_wr_d   = ref_wr_q;
        ref_rd_d   = ref_rd_q;
        match_d    = match_q;
        mm_d       = mm_q;
        error_d    = error_q;
        overflow_d = overflow_q;
        fmm_rd_d   = fmm_rd_q;
        fmm_data_d = fmm_data_q;

        if (dut_acc) begin
            dut_mem_d[dut_wr_q[AW-1:0]] = {dut_wb_rd, dut_wb_data};
            dut_wr_d = dut_wr_q + PW'(1);
        end
        if (ref_acc) begin
            ref_mem_d[ref_wr_q[AW-1:0]] = {ref_wb_rd, ref_wb_data};
            ref_wr_d = ref_wr_q + PW'(1);
        end
        if ((dut_push && !dut_acc) || (ref_push && !ref_acc))
            overflow_d = 1'b1;

        if (pop) begin
            dut_rd_d = dut_rd_q + PW'(1);
            ref_rd_d = ref_rd_q + PW'(1);
            if (dut_head == ref_head) begin
                if (match_q != '1) match_d = match_q + CNT_W'(1);
            end else begin
                if (mm_q != '1) mm_d = mm_q + CNT_W'(1);
                error_d = 1'b1;
                if (!error_q) begin
                    fmm_rd_d   = {dut_head[36:32], ref_head[36:32]};
                    fmm_data_d = {dut_head[31:0], ref_head[31:0]};
                end
                if (STOP_ON_MISMATCH != 0) state_d = S_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            dut_wr_q   <= '0;
            dut_rd_q   <= '0;
            ref_wr_q   <= '0;
            ref_rd_q   <= '0;
            match_q    <= '0;
            mm_q       <= '0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
            fmm_rd_q   <= '0;
            fmm_data_q <= '0;
        end else begin
            state_q    <= state_d;
            dut_wr_q   <= dut_wr_d;
            dut_rd_q   <= dut_rd_d;
            ref_wr_q   <= ref_wr_d;
            ref_rd_q   <= ref_rd_d;
            match_q    <= match_d;
            mm_q       <= mm_d;
            error_q    <= error_d;
            overflow_q <= overflow_d;
            fmm_rd_q   <= fmm_rd_d;
            fmm_data_q <= fmm_data_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        dut_mem_q <= dut_mem_d;
        ref_mem_q <= ref_mem_d;
    end

`ifdef SCOREBOARD_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wait_q, wait_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if (wait_q == WW'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
        if (pop || (dut_empty && ref_empty))
            wait_d = '0;
        else if ((state_q == S_RUN) && (dut_empty != ref_empty) && (wait_q != WW'(TIMEOUT_CYCLES)))
            wait_d = wait_q + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign match_count    = match_q;
    assign mismatch_count = mm_q;
    assign error          = error_q;
    assign overflow       = overflow_q;
    assign halted         = (state_q == S_HALT);
    assign pending_dut    = dut_cnt;
    assign pending_ref    = ref_cnt;
    assign first_mm_rd    = fmm_rd_q;
    assign first_mm_data  = fmm_data_q;
endmodule

// File: tb/tb_sodor5_wb_scoreboard.sv
// Directed bench for sodor5_wb_scoreboard: queue-based model checked every cycle plus literal pins.
module tb_sodor5_wb_scoreboard;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned TO    = 16;
    localparam int          MAXC  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              dut_wb_valid = 1'b0, ref_wb_valid = 1'b0;
    logic [4:0]        dut_wb_rd = '0, ref_wb_rd = '0;
    logic [31:0]       dut_wb_data = '0, ref_wb_data = '0;
    logic [CNT_W-1:0]  match_count, mismatch_count;
    logic              error, overflow, timeout, halted;
    logic [3:0]        pending_dut, pending_ref;
    logic [9:0]        first_mm_rd;
    logic [63:0]       first_mm_data;

    sodor5_wb_scoreboard #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_X0(1), .STOP_ON_MISMATCH(1), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk(clk), .reset(reset),
        .dut_wb_valid(dut_wb_valid), .dut_wb_rd(dut_wb_rd), .dut_wb_data(dut_wb_data),
        .ref_wb_valid(ref_wb_valid), .ref_wb_rd(ref_wb_rd), .ref_wb_data(ref_wb_data),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .error(error), .overflow(overflow), .timeout(timeout), .halted(halted),
        .pending_dut(pending_dut), .pending_ref(pending_ref),
        .first_mm_rd(first_mm_rd), .first_mm_data(first_mm_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: two queues of {rd,data}, counters and sticky flags.
    logic [36:0] mq_d[$];
    logic [36:0] mq_r[$];
    logic [36:0] me_d, me_r;
    int          m_match, m_mm, m_wait;
    bit          m_err, m_ovf, m_to, m_halt, m_live, m_pop;
    logic [9:0]  m_frd;
    logic [63:0] m_fdata;

    always @(posedge clk) begin
        if (reset) begin
            mq_d.delete(); mq_r.delete();
            m_match = 0; m_mm = 0; m_wait = 0;
            m_err = 0; m_ovf = 0; m_to = 0; m_halt = 0;
            m_frd = '0; m_fdata = '0;
            m_live = 1;
        end else begin
            m_pop = !m_halt && mq_d.size() > 0 && mq_r.size() > 0;
`ifdef SCOREBOARD_TIMEOUT_EN
            if (m_wait == TO) m_to = 1;
            if (m_pop || (mq_d.size() == 0 && mq_r.size() == 0)) m_wait = 0;
            else if (!m_halt && m_wait != TO) m_wait++;
`endif
            if (m_pop) begin
                me_d = mq_d.pop_front();
                me_r = mq_r.pop_front();
                if (me_d == me_r) begin
                    if (m_match < MAXC) m_match++;
                end else begin
                    if (m_mm < MAXC) m_mm++;
                    if (!m_err) begin
                        m_frd   = {me_d[36:32], me_r[36:32]};
                        m_fdata = {me_d[31:0], me_r[31:0]};
                    end
                    m_err = 1;
                    m_halt = 1;
                end
            end
            if (dut_wb_valid && dut_wb_rd != 0) begin
                if (mq_d.size() < DEPTH) mq_d.push_back({dut_wb_rd, dut_wb_data});
                else m_ovf = 1;
            end
            if (ref_wb_valid && ref_wb_rd != 0) begin
                if (mq_r.size() < DEPTH) mq_r.push_back({ref_wb_rd, ref_wb_data});
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("match_count",    64'(match_count),    64'(m_match));
            check("mismatch_count", 64'(mismatch_count), 64'(m_mm));
            check("error",          64'(error),          64'(m_err));
            check("overflow",       64'(overflow),       64'(m_ovf));
            check("timeout",        64'(timeout),        64'(m_to));
            check("halted",         64'(halted),         64'(m_halt));
            check("pending_dut",    64'(pending_dut),    64'(mq_d.size()));
            check("pending_ref",    64'(pending_ref),    64'(mq_r.size()));
            check("first_mm_rd",    64'(first_mm_rd),    64'(m_frd));
            check("first_mm_data",  first_mm_data,       m_fdata);
        end
    end

    task automatic step(input logic dv, input logic [4:0] drd, input logic [31:0] dd,
                        input logic rv, input logic [4:0] rrd, input logic [31:0] rd);
        dut_wb_valid = dv; dut_wb_rd = drd; dut_wb_data = dd;
        ref_wb_valid = rv; ref_wb_rd = rrd; ref_wb_data = rd;
        @(posedge clk); #1;
        dut_wb_valid = 1'b0; ref_wb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_match", 64'(match_count), 0);
        check("rst_halted", 64'(halted), 0);

        // 1: one equal pair
        step(1, 5, 32'h1234, 1, 5, 32'h1234);
        idle(1);
        check("s1_match", 64'(match_count), 1);
        check("s1_error", 64'(error), 0);
        check("s1_pend", 64'({pending_dut, pending_ref}), 0);

        // 2: mismatch halts, later equal pairs stay queued
        do_reset();
        step(1, 3, 32'hDEAD, 1, 3, 32'hBEEF);
        idle(1);
        check("s2_mm", 64'(mismatch_count), 1);
        check("s2_halted", 64'(halted), 1);
        check("s2_frd", 64'(first_mm_rd), 64'h063);
        check("s2_fdata", first_mm_data, 64'h0000DEAD_0000BEEF);
        step(1, 4, 32'h1, 1, 4, 32'h1);
        step(1, 6, 32'h2, 1, 6, 32'h2);
        idle(1);
        check("s2_match0", 64'(match_count), 0);
        check("s2_pend", 64'(pending_dut), 2);

        // 3: x0 writebacks dropped
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 32'(i + 7), 0, 0, 0);
        idle(2);
        check("s3_pend", 64'(pending_dut), 0);
        check("s3_to", 64'(timeout), 0);

        // 4: skewed retirement
        do_reset();
        step(1, 1, 32'hA, 0, 0, 0);
        step(1, 2, 32'hB, 0, 0, 0);
        step(1, 3, 32'hC, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 1, 32'hA);
        step(0, 0, 0, 1, 2, 32'hB);
        step(0, 0, 0, 1, 3, 32'hC);
        idle(1);
        check("s4_match", 64'(match_count), 3);
        check("s4_error", 64'(error), 0);

        // 5: overflow, then reset clears everything
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 5'(i + 1), 32'(i), 0, 0, 0);
        check("s5_pend", 64'(pending_dut), 8);
        check("s5_ovf", 64'(overflow), 1);
        do_reset();
        check("s5_rst_pend", 64'(pending_dut), 0);
        check("s5_rst_ovf", 64'(overflow), 0);

        // 6: watchdog
        do_reset();
        step(1, 7, 32'h77, 0, 0, 0);
        idle(20);
`ifdef SCOREBOARD_TIMEOUT_EN
        check("s6_to", 64'(timeout), 1);
`else
        check("s6_to", 64'(timeout), 0);
`endif

        // 7: push into a full FIFO on the same edge as a pop
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 5'(i + 1), 32'(i * 3), 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'h0);
        step(1, 9, 32'd99, 0, 0, 0);
        check("s7_pend", 64'(pending_dut), 8);
        check("s7_ovf", 64'(overflow), 0);
        check("s7_match", 64'(match_count), 1);

        // 8: counter saturation
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 2, 32'(i), 1, 2, 32'(i));
        idle(2);
        check("s8_sat", 64'(match_count), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
